// File: rtl/bldc_pkg.sv
// bldc_pkg: shared types and constants for the BLDC phase drive.
//   sel_t          - per-phase commutation select (HIGH_Z/REV/FWD/BRAKE)
//   sel_set_t      - the three phase selects {grn, ylw, blu}
//   dt_state_t     - dead-time FSM states used by phase_nonoverlap
//   commutate()    - hall state -> phase selects
//   gate_pair()    - phase select + PWM level -> desired {high, low}
package bldc_pkg;

    typedef enum logic [1:0] {
        HIGH_Z = 2'b00,
        REV    = 2'b01,
        FWD    = 2'b10,
        BRAKE  = 2'b11
    } sel_t;

    typedef struct packed {
        sel_t grn;
        sel_t ylw;
        sel_t blu;
    } sel_set_t;

    typedef enum logic {
        FOLLOW = 1'b0,
        DEAD   = 1'b1
    } dt_state_t;

    localparam int unsigned DEAD_TIME_DEFAULT = 32;
    localparam logic [10:0] MIN_DUTY_DEFAULT  = 11'h400;
    localparam logic [10:0] BRAKE_DUTY        = 11'h600;

    // Six-step commutation; the two invalid hall codes float every phase.
    function automatic sel_set_t commutate(input logic [2:0] state);
        sel_set_t s;
        s = '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
        case (state)
            3'b101:  s = '{grn: FWD,    ylw: REV,    blu: HIGH_Z};
            3'b100:  s = '{grn: FWD,    ylw: HIGH_Z, blu: REV};
            3'b110:  s = '{grn: HIGH_Z, ylw: FWD,    blu: REV};
            3'b010:  s = '{grn: REV,    ylw: FWD,    blu: HIGH_Z};
            3'b011:  s = '{grn: REV,    ylw: HIGH_Z, blu: FWD};
            3'b001:  s = '{grn: HIGH_Z, ylw: REV,    blu: FWD};
            default: s = '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
        endcase
        return s;
    endfunction

    // Desired {high, low} gate pair; brake shorts the low sides during PWM-off.
    function automatic logic [1:0] gate_pair(input sel_t sel, input logic pwm);
        logic [1:0] p;
        case (sel)
            FWD:     p = {pwm, ~pwm};
            REV:     p = {~pwm, pwm};
            BRAKE:   p = {1'b0, ~pwm};
            default: p = 2'b00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/phase_nonoverlap.sv
// phase_nonoverlap: dead-time insertion for one inverter half-bridge.
//   clk, rst            - clock, synchronous active-high reset
//   des_high, des_low   - desired gate pair for this phase
//   high, low           - registered gate drives
// Any change of the desired pair blanks both gates for DEAD_TIME clocks;
// a further change while blanked restarts the blanking interval.
module phase_nonoverlap
    import bldc_pkg::*;
#(
    parameter int unsigned DEAD_TIME = DEAD_TIME_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic des_high,
    input  logic des_low,
    output logic high,
    output logic low
);

    localparam int unsigned CNT_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

    dt_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       des_q;
    logic [1:0]       gate_d;
    logic [1:0]       des;

    assign des = {des_high, des_low};

    // The clock on which the change is seen is already blanked, so the
    // counter is loaded with DEAD_TIME-1 to give DEAD_TIME blank clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gate_d  = 2'b00;
        if (des != des_q) begin
            state_d = DEAD;
            cnt_d   = CNT_W'(DEAD_TIME - 1);
        end else if (state_q == DEAD) begin
            if (cnt_q == '0) begin
                state_d = FOLLOW;
                gate_d  = des_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            gate_d = des_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FOLLOW;
            cnt_q   <= '0;
            des_q   <= '0;
            high    <= 1'b0;
            low     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            des_q   <= des;
            high    <= gate_d[1];
            low     <= gate_d[0];
        end
    end

endmodule

// File: rtl/bldc_phase_drive.sv
// bldc_phase_drive: three-phase BLDC commutation, PWM and gate drive.
//   clk, rst                    - clock, synchronous active-high reset
//   drv_mag[11:0]               - unsigned drive magnitude
//   hallGrn/hallYlw/hallBlu     - asynchronous hall sensors
//   brake_n                     - active-low regenerative brake request
//   duty[10:0], PWM_sig         - registered PWM duty and waveform
//   selGrn/selYlw/selBlu[1:0]   - registered phase selects
//   high*/low*                  - dead-time protected gate drives
// Build option BRAKE_FIXED_DUTY_EN: while braking, duty is forced to 0x600.
module bldc_phase_drive
    import bldc_pkg::*;
#(
    parameter int unsigned DEAD_TIME = DEAD_TIME_DEFAULT,
    parameter logic [10:0] MIN_DUTY  = MIN_DUTY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] drv_mag,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    output logic [10:0] duty,
    output logic        PWM_sig,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        highGrn,
    output logic        lowGrn,
    output logic        highYlw,
    output logic        lowYlw,
    output logic        highBlu,
    output logic        lowBlu
);

    logic [2:0]  hall_meta;
    logic [2:0]  hall_sync;
    sel_set_t    sel_q;
    sel_set_t    sel_d;
    logic [10:0] duty_d;
    logic [10:0] pwm_cnt;
    logic [1:0]  des_grn, des_ylw, des_blu;

    // Two-flop synchronizer; rotation state is {Grn, Ylw, Blu}.
    always_ff @(posedge clk) begin
        if (rst) begin
            hall_meta <= '0;
            hall_sync <= '0;
        end else begin
            hall_meta <= {hallGrn, hallYlw, hallBlu};
            hall_sync <= hall_meta;
        end
    end

    always_comb begin
        sel_d = commutate(hall_sync);
        if (!brake_n) begin
            sel_d = '{grn: BRAKE, ylw: BRAKE, blu: BRAKE};
        end
    end

    // MIN_DUTY + 10-bit magnitude tops out at 0x7FF, so no saturation.
    always_comb begin
`ifdef BRAKE_FIXED_DUTY_EN
        duty_d = brake_n ? (MIN_DUTY + {1'b0, drv_mag[11:2]}) : BRAKE_DUTY;
`else
        duty_d = MIN_DUTY + {1'b0, drv_mag[11:2]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '{grn: HIGH_Z, ylw: HIGH_Z, blu: HIGH_Z};
            duty    <= '0;
            pwm_cnt <= '0;
            PWM_sig <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            duty    <= duty_d;
            pwm_cnt <= pwm_cnt + 11'd1;
            PWM_sig <= (pwm_cnt < duty);
        end
    end

    assign selGrn = sel_q.grn;
    assign selYlw = sel_q.ylw;
    assign selBlu = sel_q.blu;

    assign des_grn = gate_pair(sel_q.grn, PWM_sig);
    assign des_ylw = gate_pair(sel_q.ylw, PWM_sig);
    assign des_blu = gate_pair(sel_q.blu, PWM_sig);

    phase_nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_grn (
        .clk      (clk),
        .rst      (rst),
        .des_high (des_grn[1]),
        .des_low  (des_grn[0]),
        .high     (highGrn),
        .low      (lowGrn)
    );

    phase_nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_ylw (
        .clk      (clk),
        .rst      (rst),
        .des_high (des_ylw[1]),
        .des_low  (des_ylw[0]),
        .high     (highYlw),
        .low      (lowYlw)
    );

    phase_nonoverlap #(.DEAD_TIME(DEAD_TIME)) u_blu (
        .clk      (clk),
        .rst      (rst),
        .des_high (des_blu[1]),
        .des_low  (des_blu[0]),
        .high     (highBlu),
        .low      (lowBlu)
    );

endmodule

// File: tb/tb_bldc_phase_drive.sv
// tb_bldc_phase_drive: self-checking bench for bldc_phase_drive.
// A cycle-level reference model (commutation table, duty arithmetic,
// counter-modulo PWM and a "stable for DEAD_TIME+1 samples" gate rule)
// is compared with every output on every falling edge, alongside a
// table of directed vectors and a few hand-written sequences.
module tb_bldc_phase_drive;
    import bldc_pkg::*;

    localparam int DT   = 32;
    localparam int HIST = DT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] drv_mag = 12'h0FF;
    logic        hallGrn = 1'b0, hallYlw = 1'b0, hallBlu = 1'b0;
    logic        brake_n = 1'b1;
    logic [10:0] duty;
    logic        PWM_sig;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;

    bldc_phase_drive #(.DEAD_TIME(DT), .MIN_DUTY(11'h400)) dut (
        .clk     (clk),
        .rst     (rst),
        .drv_mag (drv_mag),
        .hallGrn (hallGrn),
        .hallYlw (hallYlw),
        .hallBlu (hallBlu),
        .brake_n (brake_n),
        .duty    (duty),
        .PWM_sig (PWM_sig),
        .selGrn  (selGrn),
        .selYlw  (selYlw),
        .selBlu  (selBlu),
        .highGrn (highGrn),
        .lowGrn  (lowGrn),
        .highYlw (highYlw),
        .lowYlw  (lowYlw),
        .highBlu (highBlu),
        .lowBlu  (lowBlu)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_valid = 1'b0;
    int m_hall1, m_hall2;          // hall sampled 1 and 2 edges ago
    int m_sel[3];
    int m_duty, m_cnt, m_pwm, m_dpwm;
    int m_last[3], m_run[3], m_gate[3];

    // phase 0 = Grn, 1 = Ylw, 2 = Blu; returns 0 HIGH_Z, 1 REV, 2 FWD
    function automatic int commute(input int st, input int phase);
        int f, r;
        f = -1; r = -1;
        case (st)
            5: begin f = 0; r = 1; end
            4: begin f = 0; r = 2; end
            6: begin f = 1; r = 2; end
            2: begin f = 1; r = 0; end
            3: begin f = 2; r = 0; end
            1: begin f = 2; r = 1; end
            default: ;
        endcase
        if (phase == f) return 2;
        if (phase == r) return 1;
        return 0;
    endfunction

    // {high, low} packed as 2*high + low
    function automatic int pair(input int sel, input int p);
        case (sel)
            2:       return p ? 2 : 1;
            1:       return p ? 1 : 2;
            3:       return p ? 0 : 1;
            default: return 0;
        endcase
    endfunction

    function automatic int duty_of(input int mag, input bit brk_n);
`ifdef BRAKE_FIXED_DUTY_EN
        if (!brk_n) return 'h600;
`endif
        return 'h400 + mag / 4;
    endfunction

    task automatic model_edge();
        int d;
        if (rst) begin
            m_valid = 1'b1;
            m_hall1 = 0; m_hall2 = 0;
            m_duty = 0; m_cnt = 0; m_pwm = 0; m_dpwm = 0;
            for (int i = 0; i < 3; i++) begin
                m_sel[i] = 0; m_last[i] = 0; m_run[i] = HIST; m_gate[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                d = pair(m_sel[i], m_pwm);
                if (d == m_last[i]) begin
                    if (m_run[i] < HIST) m_run[i]++;
                end else begin
                    m_last[i] = d;
                    m_run[i]  = 1;
                end
                m_gate[i] = (m_run[i] >= HIST) ? d : 0;
            end
            m_dpwm = m_pwm;
            m_pwm  = (m_cnt < m_duty) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % 2048;
            m_duty = duty_of(int'(drv_mag), brake_n);
            for (int i = 0; i < 3; i++)
                m_sel[i] = brake_n ? commute(m_hall2, i) : 3;
            m_hall2 = m_hall1;
            m_hall1 = int'({hallGrn, hallYlw, hallBlu});
        end
    endtask

    task automatic compare_all();
        if (!m_valid) return;
        chk("selGrn", int'(selGrn), m_sel[0]);
        chk("selYlw", int'(selYlw), m_sel[1]);
        chk("selBlu", int'(selBlu), m_sel[2]);
        chk("duty", int'(duty), m_duty);
        chk("PWM_sig", int'(PWM_sig), m_pwm);
        chk("gateGrn", int'({highGrn, lowGrn}), m_gate[0]);
        chk("gateYlw", int'({highYlw, lowYlw}), m_gate[1]);
        chk("gateBlu", int'({highBlu, lowBlu}), m_gate[2]);
        chk("overlapGrn", int'(highGrn & lowGrn), 0);
        chk("overlapYlw", int'(highYlw & lowYlw), 0);
        chk("overlapBlu", int'(highBlu & lowBlu), 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic [2:0] h, input logic bn, input logic [11:0] mag);
        {hallGrn, hallYlw, hallBlu} = h;
        brake_n = bn;
        drv_mag = mag;
    endtask

    // Measures closed runs of both-gates-low on the Grn phase.
    task automatic measure_runs(input int cycles, input int exp_len, input string name);
        int len, runs;
        bit in_run, started;
        len = 0; runs = 0; in_run = 1'b0; started = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (!highGrn && !lowGrn) begin
                if (!in_run) begin
                    in_run = 1'b1; len = 0; started = (c > 0);
                end
                len++;
            end else if (in_run) begin
                in_run = 1'b0;
                if (started) begin
                    chk(name, len, exp_len);
                    runs++;
                end
            end
        end
        chk({name, "_count"}, (runs >= 2) ? 1 : 0, 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  hall;
        logic        brk_n;
        logic [11:0] mag;
        logic [1:0]  sg, sy, sb;
        logic [10:0] duty;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int hp, cnt_hi;
        vecs[0]  = '{3'b101, 1'b1, 12'h0FF, 2'b10, 2'b01, 2'b00, 11'h43F};
        vecs[1]  = '{3'b100, 1'b1, 12'h0FF, 2'b10, 2'b00, 2'b01, 11'h43F};
        vecs[2]  = '{3'b110, 1'b1, 12'h800, 2'b00, 2'b10, 2'b01, 11'h600};
        vecs[3]  = '{3'b010, 1'b1, 12'h003, 2'b01, 2'b10, 2'b00, 11'h400};
        vecs[4]  = '{3'b011, 1'b1, 12'hFFF, 2'b01, 2'b00, 2'b10, 11'h7FF};
        vecs[5]  = '{3'b001, 1'b1, 12'h0FF, 2'b00, 2'b01, 2'b10, 11'h43F};
        vecs[6]  = '{3'b111, 1'b1, 12'h0FF, 2'b00, 2'b00, 2'b00, 11'h43F};
        vecs[7]  = '{3'b000, 1'b1, 12'h123, 2'b00, 2'b00, 2'b00, 11'h448};
`ifdef BRAKE_FIXED_DUTY_EN
        vecs[8]  = '{3'b101, 1'b0, 12'h0FF, 2'b11, 2'b11, 2'b11, 11'h600};
        vecs[9]  = '{3'b111, 1'b0, 12'hFFF, 2'b11, 2'b11, 2'b11, 11'h600};
`else
        vecs[8]  = '{3'b101, 1'b0, 12'h0FF, 2'b11, 2'b11, 2'b11, 11'h43F};
        vecs[9]  = '{3'b111, 1'b0, 12'hFFF, 2'b11, 2'b11, 2'b11, 11'h7FF};
`endif
        vecs[10] = '{3'b110, 1'b1, 12'h0FF, 2'b00, 2'b10, 2'b01, 11'h43F};

        // Reset, then hall 000: everything idle, duty settles to 0x43F.
        set_in(3'b000, 1'b1, 12'h0FF);
        rst = 1'b1;
        repeat (3) step();
        chk("rst_duty", int'(duty), 0);
        chk("rst_pwm", int'(PWM_sig), 0);
        chk("rst_sel", int'({selGrn, selYlw, selBlu}), 0);
        chk("rst_gates", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 0);
        rst = 1'b0;
        repeat (2) step();
        chk("init_duty", int'(duty), 'h43F);
        chk("init_sel", int'({selGrn, selYlw, selBlu}), 0);
        chk("init_gates", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 0);

        // Table: each state held 36 clocks, then selects/duty/gate roles.
        foreach (vecs[i]) begin
            set_in(vecs[i].hall, vecs[i].brk_n, vecs[i].mag);
            repeat (36) step();
            chk("vec_selGrn", int'(selGrn), int'(vecs[i].sg));
            chk("vec_selYlw", int'(selYlw), int'(vecs[i].sy));
            chk("vec_selBlu", int'(selBlu), int'(vecs[i].sb));
            chk("vec_duty", int'(duty), int'(vecs[i].duty));
            // Role check skipped for a phase still blanked by a PWM edge.
            if (m_run[0] >= HIST) chk("vec_roleGrn", int'({highGrn, lowGrn}), pair(int'(vecs[i].sg), m_dpwm));
            if (m_run[1] >= HIST) chk("vec_roleYlw", int'({highYlw, lowYlw}), pair(int'(vecs[i].sy), m_dpwm));
            if (m_run[2] >= HIST) chk("vec_roleBlu", int'({highBlu, lowBlu}), pair(int'(vecs[i].sb), m_dpwm));
        end

        // Grn driven FWD at moderate duty: isolated PWM edges blank exactly DT clocks.
        set_in(3'b101, 1'b1, 12'h0FF);
        repeat (40) step();
        measure_runs(4200, DT, "deadrun_mid");

        // Full duty: PWM low one clock in 2048, so fall and rise are adjacent
        // and their blanking windows merge into DT+1 clocks.
        set_in(3'b101, 1'b1, 12'hFFF);
        repeat (2100) step();
        cnt_hi = 0;
        for (int c = 0; c < 2048; c++) begin
            step();
            if (PWM_sig) cnt_hi++;
        end
        chk("pwm_high_count", cnt_hi, 2047);
        measure_runs(4200, DT + 1, "deadrun_full");

        // Reset mid-drive.
        set_in(3'b100, 1'b1, 12'h800);
        repeat (40) step();
        rst = 1'b1;
        step();
        chk("midrst_gates", int'({highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}), 0);
        chk("midrst_pwm", int'(PWM_sig), 0);
        chk("midrst_duty", int'(duty), 0);
        chk("midrst_sel", int'({selGrn, selYlw, selBlu}), 0);
        rst = 1'b0;

        // Randomized traffic against the model, including glitches and resets.
        for (int s = 0; s < 80; s++) begin
            set_in(3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0), 12'($urandom));
            rst = ($urandom_range(0, 12) == 0);
            hp = rst ? 1 : int'($urandom_range(1, 70));
            repeat (hp) step();
            rst = 1'b0;
        end
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
